// File: rtl/cnc_uart_pkg.sv
// Shared definitions for the frame serializer: state encoding, default baud
// divisor and frame length.
package cnc_uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;
  localparam int FRAME_LEN            = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: bit_tick is high for one cycle at the end of every
// CLKS_PER_BIT-cycle bit period; clr realigns the period to a new character.
module uart_baud_gen
  import cnc_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == LAST_CNT)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = (cnt_q == LAST_CNT) && !clr;

endmodule

// File: rtl/frame_uart_tx.sv
// Frame serializer: walks the byte-mux select 0..7 and sends each selected
// byte as one UART 8N1 character, LSB first.
module frame_uart_tx
  import cnc_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FRAME_LEN    = cnc_uart_pkg::FRAME_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic [2:0] sel,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       bit_tick;
  logic       baud_clr;

  // Holding the divider clear through IDLE and LOAD makes the first bit
  // period start exactly on the edge that enters START.
  assign baud_clr = (state_q == IDLE) || (state_q == LOAD);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (baud_clr),
    .bit_tick(bit_tick)
  );

  // tx is computed for the next state so the line is registered and changes
  // on the same edge as the state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        idx_d = '0;
        if (start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        shreg_d = data_in;
        bit_d   = '0;
        tx_d    = 1'b0;
        state_d = START;
      end
      START: begin
        if (bit_tick) begin
          tx_d    = shreg_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = LOAD;
          end
        end
      end
      default: begin
        idx_d   = '0;
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sel  = idx_q;
  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
